dm_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that acts as a responder on the CPU data-memory bus: chip-select, read and write strobes, 32-bit address, write data and read data.
- Sits beside the data memory. Top-level decode drives its chip-select for the peripheral window.
- CPU stores bytes into a small TX FIFO. An FSM serialises them as 8N1 frames on txd.
- Reads are combinational, matching the single-cycle core. No wait states.

---
 rtl/dm_uart_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_dm_uart_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_uart_tx.sv
// dm_uart_tx: memory-mapped 8N1 UART transmitter on the data-memory bus.
//
// A 16-byte window at BASE_ADDR holds four word registers (select = addr[3:2]):
//   0 TXDATA  (WO)  write pushes wdata[7:0] into the TX FIFO; reads 0
//   1 STATUS  (RO except bit3) {count[7:4], ovf[3], empty[2], full[1], busy[0]}
//                   writing wdata[3]=1 clears the sticky ovf flag
//   2 BAUDDIV (RW)  bits[15:0], clk cycles per bit (0 behaves as 1)
//   3 reserved      reads 0, writes ignored
//
// Ports:
//   clk    system clock, all state updates on posedge
//   rst    asynchronous active-high reset
//   cs     chip-select from top-level decode
//   rd     read strobe (rdata is combinational)
//   wr     write strobe, sampled at posedge clk
//   addr   byte address
//   wdata  write data
//   rdata  read data, 0 unless a read-only access hits the window
//   txd    registered serial output, idles high
//   idle   FIFO empty and FSM idle
module dm_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        idle
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Bus decode
   logic       hit;
   logic [1:0] sel;
   logic       push_req;
   logic       push_ok;
   logic       pop;

   assign hit      = cs & (addr[31:4] == BASE_ADDR[31:4]);
   assign sel      = addr[3:2];
   assign push_req = hit & wr & (sel == 2'd0);

   // FIFO state
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            full;
   logic            empty;
   logic [7:0]      head;

   assign full  = (count_q == CntW'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rptr_q];

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push_ok = push_req & (~full | pop);

   // Control registers
   logic        ovf_q, ovf_d;
   logic [15:0] baud_q, baud_d;

   // Transmit FSM state
   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        txd_q, txd_d;
   logic        bit_end;
   logic [15:0] reload;

   assign bit_end = (cnt_q == 16'd0);
   // Bit time is max(BAUDDIV, 1); the counter runs reload..0.
   assign reload  = (baud_q == 16'd0) ? 16'd0 : baud_q - 16'd1;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) wptr_d = wptr_q + PtrW'(1);
      if (pop)     rptr_d = rptr_q + PtrW'(1);
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      ovf_d  = ovf_q;
      baud_d = baud_q;
      if (push_req && !push_ok) begin
         ovf_d = 1'b1;
      end else if (hit && wr && (sel == 2'd1) && wdata[3]) begin
         ovf_d = 1'b0;
      end
      if (hit && wr && (sel == 2'd2)) baud_d = wdata[15:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               cnt_d   = reload;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               cnt_d   = reload;
               idx_d   = 3'd0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d   = reload;
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = StStop;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StStop: begin
            if (bit_end) begin
               if (!empty) begin
                  // Back-to-back frame: no idle cycle between stop and start.
                  pop     = 1'b1;
                  shift_d = head;
                  cnt_d   = reload;
                  state_d = StStart;
               end else begin
                  cnt_d   = 16'd0;
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // txd follows the state one cycle later, so it falls one cycle after the pop edge.
   always_comb begin
      unique case (state_q)
         StStart: txd_d = 1'b0;
         StData:  txd_d = shift_q[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         baud_q  <= DIV_RESET;
         state_q <= StIdle;
         cnt_q   <= 16'd0;
         idx_q   <= 3'd0;
         shift_q <= 8'd0;
         txd_q   <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         baud_q  <= baud_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= wdata[7:0];
   end

   // Read path
   logic [31:0] count_ext;
   logic [3:0]  count_sat;

   assign count_ext = 32'(count_q);
   assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

   always_comb begin
      rdata = 32'h0;
      if (hit && rd && !wr && !rst) begin
         unique case (sel)
            2'd1:    rdata = {24'h0, count_sat, ovf_q, empty, full, (state_q != StIdle)};
            2'd2:    rdata = {16'h0, baud_q};
            default: rdata = 32'h0;
         endcase
      end
   end

   assign txd  = txd_q;
   assign idle = empty & (state_q == StIdle);

   logic unused_bits;
   assign unused_bits = ^{addr[1:0], wdata[31:16]};

endmodule

// File: tb/tb_dm_uart_tx.sv
module tb_dm_uart_tx;

   localparam logic [31:0] Base  = 32'h0000_1000;
   localparam int          Depth = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs, rd, wr;
   logic [31:0] addr, wdata, rdata;
   logic        txd, idle;

   int n_tests = 0;
   int n_fail  = 0;

   dm_uart_tx #(
      .BASE_ADDR (Base),
      .FIFO_DEPTH(Depth),
      .DIV_RESET (16'd16)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .cs   (cs),
      .rd   (rd),
      .wr   (wr),
      .addr (addr),
      .wdata(wdata),
      .rdata(rdata),
      .txd  (txd),
      .idle (idle)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bus tasks are entered at a negedge; writes consume one posedge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      #1 d = rdata;
      cs = 1'b0; rd = 1'b0; addr = 32'h0;
   endtask

   task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check_eq(tag, d, exp);
   endtask

   // Waits for a start bit (or demands it on the very next sample when immediate),
   // then checks every cycle of all ten bit times against the ideal 8N1 waveform.
   task automatic capture_frame(input logic [7:0] exp_b, input int div, input bit immediate,
                                input bit last, output int waits);
      int   limit;
      int   bad;
      logic lvl;
      limit = immediate ? 1 : 40 * div + 20;
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (txd !== 1'b0 && waits < limit);
      check_eq($sformatf("start_of_%02h", exp_b), 32'(txd), 32'h0);
      if (txd !== 1'b0) return;
      for (int b = 0; b < 10; b++) begin
         if (b == 0)      lvl = 1'b0;
         else if (b == 9) lvl = 1'b1;
         else             lvl = exp_b[b-1];
         bad = 0;
         for (int k = 0; k < div; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (txd !== lvl) bad++;
         end
         check_eq($sformatf("bit%0d_of_%02h_badcycles", b, exp_b), 32'(bad), 32'h0);
      end
      check_eq($sformatf("idle_after_%02h", exp_b), 32'(idle), 32'(last));
   endtask

   // Back-to-back pushes starting from an idle transmitter. The reference is a plain
   // occupancy count: the head leaves one cycle after the first push, and later pushes
   // land only while fewer than Depth bytes are waiting.
   task automatic run_burst(input logic [7:0] bytes[$], input int div);
      logic [7:0]  sent[$];
      int          occ;
      bit          ovf;
      int          cnt;
      int          w;
      logic [31:0] exp_st;
      logic [31:0] st;
      occ = 0;
      ovf = 1'b0;
      for (int k = 0; k < bytes.size(); k++) begin
         if (occ < Depth || k == 1) begin
            sent.push_back(bytes[k]);
            occ = occ + 1 - ((k == 1) ? 1 : 0);
         end else begin
            ovf = 1'b1;
         end
      end
      cnt = sent.size() - 1;
      bus_write(Base + 32'h8, 32'(div));
      fork
         begin
            for (int k = 0; k < bytes.size(); k++) bus_write(Base, {24'h0, bytes[k]});
            @(negedge clk);
            exp_st = {24'h0, 4'(cnt), ovf, (cnt == 0), (cnt == Depth), 1'b1};
            bus_read(Base + 32'h4, st);
            check_eq($sformatf("burst_status_n%0d", bytes.size()), st, exp_st);
            if (ovf) begin
               bus_write(Base + 32'h4, 32'h8);
               exp_st[3] = 1'b0;
               bus_read(Base + 32'h4, st);
               check_eq("ovf_cleared", st, exp_st);
            end
         end
         begin
            for (int i = 0; i < sent.size(); i++)
               capture_frame(sent[i], div, (i > 0), (i == sent.size() - 1), w);
         end
      join
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] q[$];
      int         w;
      int         div;
      int         n;

      rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
      repeat (2) @(negedge clk);
      check_eq("reset_txd", 32'(txd), 32'h1);
      check_eq("reset_idle", 32'(idle), 32'h1);
      rst = 1'b0;
      @(negedge clk);
      read_check("reset_status", Base + 32'h4, 32'h0000_0004);
      read_check("reset_bauddiv", Base + 32'h8, 32'h0000_0010);
      read_check("txdata_reads_0", Base + 32'h0, 32'h0);
      read_check("reserved_reads_0", Base + 32'hC, 32'h0);

      // Single 0x55 frame at 4 cycles per bit, plus push-to-start latency.
      bus_write(Base + 32'h8, 32'd4);
      bus_write(Base, 32'h55);
      capture_frame(8'h55, 4, 1'b0, 1'b1, w);
      check_eq("push_to_start_latency", 32'(w), 32'd2);

      // Four back-to-back frames, then a FIFO overflow.
      q = {8'hA3, 8'h0F, 8'hFF, 8'h00};
      run_burst(q, 2);
      q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      run_burst(q, 16);

      // Decode: outside window, deselected, reserved, and simultaneous rd/wr.
      bus_write(Base + 32'h10, 32'h12);
      cs = 1'b0; wr = 1'b1; addr = Base; wdata = 32'h34;
      @(negedge clk);
      wr = 1'b0; addr = 32'h0; wdata = 32'h0;
      repeat (4) @(negedge clk);
      check_eq("no_push_idle", 32'(idle), 32'h1);
      check_eq("no_push_txd", 32'(txd), 32'h1);
      read_check("no_push_status", Base + 32'h4, 32'h4);
      read_check("outside_window_read", Base + 32'h14, 32'h0);
      cs = 1'b0; rd = 1'b1; addr = Base + 32'h8;
      #1 check_eq("cs_low_read", rdata, 32'h0);
      rd = 1'b0;
      cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = Base + 32'h8; wdata = 32'h0001_0003;
      #1 check_eq("rd_wr_read_zero", rdata, 32'h0);
      @(negedge clk);
      cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
      bus_write(Base + 32'hC, 32'hFFFF_FFFF);
      read_check("bauddiv_after_rdwr", Base + 32'h8, 32'h3);
      read_check("status_after_reserved", Base + 32'h4, 32'h4);

      // BAUDDIV = 0 behaves as one cycle per bit.
      bus_write(Base + 32'h8, 32'h0);
      bus_write(Base, 32'hC6);
      capture_frame(8'hC6, 1, 1'b0, 1'b1, w);
      check_eq("div0_latency", 32'(w), 32'd2);

      // Randomised bursts.
      for (int it = 0; it < 6; it++) begin
         div = $urandom_range(2, 6);
         n   = $urandom_range(1, 6);
         q   = {};
         for (int k = 0; k < n; k++) q.push_back(8'($urandom));
         run_burst(q, div);
      end

      // Reset in the middle of a frame.
      bus_write(Base + 32'h8, 32'd8);
      bus_write(Base, 32'h3C);
      repeat (32) @(negedge clk);
      check_eq("mid_frame_busy", 32'(idle), 32'h0);
      rst = 1'b1;
      #1 check_eq("reset_txd_async", 32'(txd), 32'h1);
      check_eq("reset_idle_async", 32'(idle), 32'h1);
      cs = 1'b1; rd = 1'b1; addr = Base + 32'h8;
      #1 check_eq("read_during_reset", rdata, 32'h0);
      cs = 1'b0; rd = 1'b0; addr = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      read_check("post_reset_status", Base + 32'h4, 32'h4);
      read_check("post_reset_bauddiv", Base + 32'h8, 32'h10);
      bus_write(Base, 32'h81);
      capture_frame(8'h81, 16, 1'b0, 1'b1, w);
      check_eq("post_reset_latency", 32'(w), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
